// File: rtl/student_fir_out_requant.sv
// FIR output requantiser: round, shift and saturate each FIR result to codec width,
// then buffer the samples in a small FIFO that the I2S transmitter drains once per frame.
module student_fir_out_requant #(
    parameter int DATA_SIZE_FIR_OUT = 32,
    parameter int DATA_SIZE         = 16,
    parameter int SHIFT             = 15,
    parameter int DEPTH             = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] y_i,
    input  logic                         y_valid_i,
    input  logic                         sample_req_i,
    output logic [DATA_SIZE-1:0]         sample_o,
    output logic                         sample_valid_o,
    input  logic                         clear_i,
    output logic                         overflow_o,
    output logic                         underrun_o,
    output logic [15:0]                  sat_cnt_o,
    output logic [$clog2(DEPTH):0]       level_o
);

    localparam int WE = DATA_SIZE_FIR_OUT + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic signed [WE-1:0] HALF = {{(WE-1){1'b0}}, 1'b1} << (SHIFT - 1);

    logic signed [WE-1:0] ext;
    logic signed [WE-1:0] rnd;
    logic signed [WE-1:0] r1;
    logic                 v1;

    // One extra bit of headroom keeps the rounding addition from wrapping.
    assign ext = signed'({y_i[DATA_SIZE_FIR_OUT-1], y_i});
    assign rnd = (ext + HALF) >>> SHIFT;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= y_valid_i;
            if (y_valid_i) r1 <= rnd;
        end
    end

    logic [WE-DATA_SIZE:0] hi;
    logic                  in_range;
    logic [DATA_SIZE-1:0]  sat_val;
    logic [DATA_SIZE-1:0]  s2_next;
    logic                  sat_evt;
    logic [DATA_SIZE-1:0]  s2;
    logic                  v2;

    // In range exactly when every bit above the sample sign bit matches it.
    assign hi       = r1[WE-1:DATA_SIZE-1];
    assign in_range = (&hi) | (~|hi);
    assign sat_val  = r1[WE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                               : {1'b0, {(DATA_SIZE-1){1'b1}}};
    assign s2_next  = in_range ? r1[DATA_SIZE-1:0] : sat_val;
    assign sat_evt  = v1 & ~in_range;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2 <= '0;
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) s2 <= s2_next;
        end
    end

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 wr;
    logic                 ovf_evt;
    logic                 unr_evt;

    assign full    = (level == FULL);
    assign empty   = (level == '0);
    assign pop     = sample_req_i & ~empty;
    assign wr      = v2 & (~full | pop);
    assign ovf_evt = v2 & full & ~pop;
    assign unr_evt = sample_req_i & empty;
    assign level_o = level;

    always_ff @(posedge clk_i) begin
        if (wr) mem[wr_ptr] <= s2;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // On underrun sample_o holds, but the strobe still fires so I2S always transmits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
        end else begin
            sample_valid_o <= sample_req_i;
            if (pop) sample_o <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
            underrun_o <= 1'b0;
            sat_cnt_o  <= '0;
        end else begin
            if (ovf_evt)      overflow_o <= 1'b1;
            else if (clear_i) overflow_o <= 1'b0;
            if (unr_evt)      underrun_o <= 1'b1;
            else if (clear_i) underrun_o <= 1'b0;
            if (clear_i)
                sat_cnt_o <= {15'd0, sat_evt};
            else if (sat_evt && !(&sat_cnt_o))
                sat_cnt_o <= sat_cnt_o + 16'd1;
        end
    end

endmodule

// File: doc/student_fir_out_requant.md
Name: student_fir_out_requant

Overview:
Output stage between the FIR engine and the I2S handler.
- Accepts full-width FIR results with their compute-finished strobe.
- Rounds, arithmetic-shifts and saturates each result to codec sample width.
- Buffers the results in a small FIFO and hands one sample to the I2S transmitter per frame request.
- Absorbs jitter between FIR completion and LRCLK timing. Flags overflow, underrun and saturation for debug.

Parameters:
- DATA_SIZE_FIR_OUT, 32: width of the signed FIR accumulator input.
- DATA_SIZE, 16: width of the signed codec output sample.
- SHIFT, 15: right-shift applied to the result (Q1.15 coefficients). Legal range 1..DATA_SIZE_FIR_OUT-DATA_SIZE.
- DEPTH, 4: FIFO entries. Power of two, at least 2.

Ports:
- clk_i, in, 1: system clock.
- rst_i, in, 1: reset. Asynchronous, active-high.
- y_i, in, DATA_SIZE_FIR_OUT: signed FIR result.
- y_valid_i, in, 1: one-cycle strobe qualifying y_i.
- sample_req_i, in, 1: one-cycle request from I2S for the next sample.
- sample_o, out, DATA_SIZE: signed sample presented to I2S.
- sample_valid_o, out, 1: one-cycle strobe, sample_o updated.
- clear_i, in, 1: synchronous clear of sticky flags and the saturation counter.
- overflow_o, out, 1: sticky flag, a result was dropped because the FIFO was full.
- underrun_o, out, 1: sticky flag, a request arrived while the FIFO was empty.
- sat_cnt_o, out, 16: count of saturated samples. Saturates at 0xFFFF.
- level_o, out, $clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (rst_i high, asynchronous):
  - All outputs 0, FIFO pointers 0, pipeline valid bits 0.
  - Reset asserted mid-operation discards pipeline and FIFO contents immediately.
- Stage 1, capture y_valid_i at cycle t: r1 = (sign-extend(y_i, +1 bit) + 2^(SHIFT-1)) >>> SHIFT.
  - Width is DATA_SIZE_FIR_OUT+1, so the round addition cannot wrap.
- Stage 2, registered at end of cycle t+1:
  - r1 > 2^(DATA_SIZE-1)-1 saturates to 0x7FFF (for DATA_SIZE=16).
  - r1 < -2^(DATA_SIZE-1) saturates to 0x8000 (for DATA_SIZE=16).
  - Otherwise the low DATA_SIZE bits are taken.
  - A saturation event increments sat_cnt_o, which holds at 0xFFFF.
- FIFO write: at the edge ending cycle t+2.
  - Entry is poppable from cycle t+3. Total latency from y_valid_i to FIFO is 3 clocks.
  - Back-to-back y_valid_i strobes are fully pipelined.
- Pop: when sample_req_i=1 and level>0, the head is loaded into sample_o at the next edge.
  - sample_valid_o=1 for exactly that one cycle.
  - Read pointer advances and level decrements.
- Underrun: sample_req_i=1 with level=0.
  - sample_o holds its last value (0 after reset).
  - sample_valid_o still pulses, so the I2S always transmits.
  - underrun_o is set.
  - No bypass: a write landing in the same cycle is not forwarded.
- Overflow: a write with level=DEPTH and no simultaneous pop drops the new sample.
  - FIFO is unchanged, overflow_o is set.
- Simultaneous write and pop when full: pop first, then write. No overflow, level stays DEPTH.
- Simultaneous write and pop otherwise: level unchanged.
- Pointers wrap modulo DEPTH. level_o distinguishes full from empty.
- clear_i:
  - Zeroes overflow_o, underrun_o and sat_cnt_o.
  - A flag event or saturation in the same cycle wins (flag set, counter becomes 1).
  - Does not touch FIFO data, pointers or sample_o.
- sample_req_i and y_valid_i are assumed to be single-cycle pulses. A held level is treated as one request per cycle.

Test Plan:
1. Reset with rst_i=1 mid-stream, all pipeline and FIFO entries in flight -> all outputs 0 asynchronously. After release, the first sample_req_i gives sample_o=0x0000, sample_valid_o=1, underrun_o=1.
2. Rounding, SHIFT=15:
   - y_i=0x0000_4000 -> sample 0x0001.
   - y_i=0x0000_3FFF -> sample 0x0000.
   - y_i=0xFFFF_8000 -> sample 0xFFFF.
   - Each sample is poppable 3 cycles after its strobe. sat_cnt_o stays 0.
3. Saturation:
   - y_i=0x7FFF_FFFF -> 0x7FFF.
   - y_i=0x8000_0000 -> 0x8000.
   - sat_cnt_o=2 afterwards.
   - Preload sat_cnt to 0xFFFF, then apply a further saturation -> stays 0xFFFF.
4. Overflow with DEPTH=4: five results, no requests.
   - level_o=4, overflow_o=1.
   - Four pops return the first four results in order; the fifth is lost.
   - level_o=0 afterwards.
5. Full plus simultaneous events: FIFO full, a write and sample_req_i in the same cycle -> head popped, new sample stored, level_o stays 4, overflow_o stays 0.
6. clear_i asserted in the same cycle as an underrun request -> underrun_o=1 next cycle, sat_cnt_o=0. clear_i alone on the next cycle -> underrun_o=0.
